// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with iterative 32x32 multiply/divide
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   iHiLoWrite   update request (MOVE or MULT/DIV start)
//   iHL          1 = HI, 0 = LO; read select and move target
//   iALUc        1100 MULT, 1101 MULTU, 1110 DIV, 1111 DIVU, 0xxx MOVE, 10xx ignored
//   iRegOut1     rs operand (dividend / multiplicand / move data)
//   iRegOut2     rt operand (divisor / multiplier)
//   oHiLoOut     iHL ? HI : LO
//   oBusy        operation in flight (IDLE accept edge through FIX edge)
//   oDone        one-cycle pulse after the edge that writes the result
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iHiLoWrite,
    input  logic        iHL,
    input  logic [3:0]  iALUc,
    input  logic [31:0] iRegOut1,
    input  logic [31:0] iRegOut2,
    output logic [31:0] oHiLoOut,
    output logic        oBusy,
    output logic        oDone
);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] acc_q, acc_d;   // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [31:0] m_q;            // multiplicand (mult) or divisor (div) magnitude
    logic [31:0] orig_q;         // raw dividend, reported as HI on divide by zero
    logic        mul_q, qneg_q, rneg_q, div0_q;
    logic        busy_q, done_q;

    // Operand decode for the accept edge
    logic        is_mul, is_signed, rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign is_mul    = ~iALUc[1];
    assign is_signed = ~iALUc[0];
    assign rs_neg    = is_signed & iRegOut1[31];
    assign rt_neg    = is_signed & iRegOut2[31];
    assign rs_mag    = rs_neg ? (~iRegOut1 + 32'd1) : iRegOut1;
    assign rt_mag    = rt_neg ? (~iRegOut2 + 32'd1) : iRegOut2;

    // One iteration of shift-add multiply or restoring divide
    logic [32:0] mul_sum;
    logic [33:0] div_diff;

    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, m_q} : 33'd0);
        // Shifted remainder needs 33 bits since it can reach 2*divisor-1
        div_diff = {1'b0, acc_q[63:31]} - {2'b00, m_q};
        acc_d    = acc_q;
        if (mul_q)
            acc_d = {mul_sum, acc_q[31:1]};
        else if (div_diff[33])
            acc_d = {acc_q[62:0], 1'b0};
        else
            acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
    end

    // Sign correction and divide-by-zero override for the FIX edge
    logic [63:0] prod_fix;
    logic [31:0] hi_d, lo_d;

    always_comb begin
        prod_fix = qneg_q ? (~acc_q + 64'd1) : acc_q;
        hi_d     = prod_fix[63:32];
        lo_d     = prod_fix[31:0];
        if (!mul_q) begin
            if (div0_q) begin
                lo_d = 32'hFFFF_FFFF;
                hi_d = orig_q;
            end else begin
                lo_d = qneg_q ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
                hi_d = rneg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            acc_q   <= 64'd0;
            m_q     <= 32'd0;
            orig_q  <= 32'd0;
            mul_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (iHiLoWrite) begin
                        if (!iALUc[3]) begin
                            if (iHL) hi_q <= iRegOut1;
                            else     lo_q <= iRegOut1;
                        end else if (iALUc[2]) begin
                            mul_q   <= is_mul;
                            m_q     <= is_mul ? rs_mag : rt_mag;
                            acc_q   <= {32'd0, is_mul ? rt_mag : rs_mag};
                            qneg_q  <= rs_neg ^ rt_neg;
                            rneg_q  <= rs_neg;
                            div0_q  <= ~is_mul & (iRegOut2 == 32'd0);
                            orig_q  <= iRegOut1;
                            cnt_q   <= 5'd0;
                            busy_q  <= 1'b1;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign oHiLoOut = iHL ? hi_q : lo_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;

    logic        clk;
    logic        rst_n;
    logic        iHiLoWrite;
    logic        iHL;
    logic [3:0]  iALUc;
    logic [31:0] iRegOut1;
    logic [31:0] iRegOut2;
    logic [31:0] oHiLoOut;
    logic        oBusy;
    logic        oDone;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;
    localparam logic [3:0] OP_MOVE  = 4'b0000;

    hilo_muldiv dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .iHiLoWrite (iHiLoWrite),
        .iHL        (iHL),
        .iALUc      (iALUc),
        .iRegOut1   (iRegOut1),
        .iRegOut2   (iRegOut2),
        .oHiLoOut   (oHiLoOut),
        .oBusy      (oBusy),
        .oDone      (oDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for oDone, counting edges and busy samples; bounded at 100 edges
    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (oDone !== 1'b1 && n < 100) begin
            if (oBusy === 1'b1) bc++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one request, scramble operands after acceptance, wait for completion
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n, output int bc);
        iHiLoWrite = 1'b1; iALUc = op; iRegOut1 = a; iRegOut2 = b;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0; iRegOut1 = 32'h5A5A_5A5A; iRegOut2 = 32'h0000_0003;
        wait_done(n, bc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iHiLoWrite = 1'b0; iHL = 1'b0; iALUc = 4'd0;
        iRegOut1 = 32'd0; iRegOut2 = 32'd0;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (oHiLoOut !== 32'd0) begin n_bad++; $display("FAIL reset_lo: got %h expected 0", oHiLoOut); end
        iHL = 1'b1; #1;
        n_cmp++; if (oHiLoOut !== 32'd0) begin n_bad++; $display("FAIL reset_hi: got %h expected 0", oHiLoOut); end
        n_cmp++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin n_bad++; $display("FAIL reset_flags: busy %b done %b expected 0 0", oBusy, oDone); end
        rst_n = 1'b1;
    endtask

    task automatic test_arith(input string name, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n, bc;
        do_op(op, a, b, n, bc);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL %s_latency: got %0d edges expected 33", name, n); end
        n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL %s_busy: got %0d cycles expected 33", name, bc); end
        n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL %s_busy_clear: got %b expected 0", name, oBusy); end
        iHL = 1'b1; #1;
        n_cmp++; if (oHiLoOut !== exp_hi) begin n_bad++; $display("FAIL %s_hi: got %h expected %h", name, oHiLoOut, exp_hi); end
        iHL = 1'b0; #1;
        n_cmp++; if (oHiLoOut !== exp_lo) begin n_bad++; $display("FAIL %s_lo: got %h expected %h", name, oHiLoOut, exp_lo); end
        @(posedge clk); #1;
        n_cmp++; if (oDone !== 1'b0) begin n_bad++; $display("FAIL %s_done_pulse: got %b expected 0", name, oDone); end
    endtask

    task automatic test_move();
        iHiLoWrite = 1'b1; iALUc = OP_MOVE; iHL = 1'b1; iRegOut1 = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0;
        n_cmp++; if (oHiLoOut !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL move_hi: got %h expected deadbeef", oHiLoOut); end
        n_cmp++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin n_bad++; $display("FAIL move_flags: busy %b done %b expected 0 0", oBusy, oDone); end
        iHiLoWrite = 1'b1; iALUc = 4'b0101; iHL = 1'b0; iRegOut1 = 32'h1111_1111;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0;
        n_cmp++; if (oHiLoOut !== 32'h1111_1111) begin n_bad++; $display("FAIL move_lo: got %h expected 11111111", oHiLoOut); end
    endtask

    task automatic test_ignored();
        iHiLoWrite = 1'b1; iALUc = 4'b1000; iHL = 1'b0; iRegOut1 = 32'h2222_2222; iRegOut2 = 32'd5;
        @(posedge clk); #1;
        iALUc = 4'b1011; iHL = 1'b1;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0;
        n_cmp++; if (oHiLoOut !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL ignored_hi: got %h expected deadbeef", oHiLoOut); end
        iHL = 1'b0; #1;
        n_cmp++; if (oHiLoOut !== 32'h1111_1111) begin n_bad++; $display("FAIL ignored_lo: got %h expected 11111111", oHiLoOut); end
        n_cmp++; if (oBusy !== 1'b0) begin n_bad++; $display("FAIL ignored_busy: got %b expected 0", oBusy); end
    endtask

    task automatic test_move_during_busy();
        int n, bc;
        iHiLoWrite = 1'b1; iALUc = OP_MULTU; iRegOut1 = 32'd3; iRegOut2 = 32'd4;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0;
        repeat (5) @(posedge clk); #1;
        iHiLoWrite = 1'b1; iALUc = OP_MOVE; iHL = 1'b1; iRegOut1 = 32'h1234_5678;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0;
        n_cmp++; if (oHiLoOut !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL busy_old_hi: got %h expected deadbeef", oHiLoOut); end
        n_cmp++; if (oBusy !== 1'b1) begin n_bad++; $display("FAIL busy_mid: got %b expected 1", oBusy); end
        wait_done(n, bc);
        n_cmp++; if (n !== 27) begin n_bad++; $display("FAIL busy_move_latency: got %0d edges expected 27", n); end
        n_cmp++; if (oHiLoOut !== 32'd0) begin n_bad++; $display("FAIL busy_move_hi: got %h expected 0", oHiLoOut); end
        iHL = 1'b0; #1;
        n_cmp++; if (oHiLoOut !== 32'd12) begin n_bad++; $display("FAIL busy_move_lo: got %h expected c", oHiLoOut); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int n, bc;
        iHiLoWrite = 1'b1; iALUc = OP_DIVU; iRegOut1 = 32'd20; iRegOut2 = 32'd3;
        @(posedge clk); #1;
        wait_done(n, bc);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL b2b_first_latency: got %0d edges expected 33", n); end
        iHL = 1'b0; #1;
        n_cmp++; if (oHiLoOut !== 32'd6) begin n_bad++; $display("FAIL b2b_first_lo: got %h expected 6", oHiLoOut); end
        iRegOut1 = 32'd29; iRegOut2 = 32'd4;
        @(posedge clk); #1;
        n_cmp++; if (oBusy !== 1'b1 || oDone !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: busy %b done %b expected 1 0", oBusy, oDone); end
        iHiLoWrite = 1'b0;
        wait_done(n, bc);
        n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL b2b_second_latency: got %0d edges expected 33", n); end
        n_cmp++; if (oHiLoOut !== 32'd7) begin n_bad++; $display("FAIL b2b_second_lo: got %h expected 7", oHiLoOut); end
        iHL = 1'b1; #1;
        n_cmp++; if (oHiLoOut !== 32'd1) begin n_bad++; $display("FAIL b2b_second_hi: got %h expected 1", oHiLoOut); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int dones = 0;
        iHiLoWrite = 1'b1; iALUc = OP_DIVU; iRegOut1 = 32'd1000; iRegOut2 = 32'd7;
        @(posedge clk); #1;
        iHiLoWrite = 1'b0;
        repeat (11) @(posedge clk); #1;
        rst_n = 1'b0; #1;
        iHL = 1'b1; #1;
        n_cmp++; if (oHiLoOut !== 32'd0) begin n_bad++; $display("FAIL midreset_hi: got %h expected 0", oHiLoOut); end
        iHL = 1'b0; #1;
        n_cmp++; if (oHiLoOut !== 32'd0) begin n_bad++; $display("FAIL midreset_lo: got %h expected 0", oHiLoOut); end
        n_cmp++; if (oBusy !== 1'b0 || oDone !== 1'b0) begin n_bad++; $display("FAIL midreset_flags: busy %b done %b expected 0 0", oBusy, oDone); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (oDone === 1'b1) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d pulses expected 0", dones); end
    endtask

    initial begin
        test_reset();
        test_arith("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
        test_arith("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        test_arith("mult_nn",   OP_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6);
        test_arith("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        test_arith("div_negd",  OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        test_arith("divu_zero", OP_DIVU,  32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        test_arith("div_zero",  OP_DIV,   32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        test_arith("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        test_move();
        test_ignored();
        test_move_during_busy();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
